// File: rtl/rf_pkg.sv
// Shared constants for the multiport register file: default geometry and the
// soft-clear sequencer state encoding.
package rf_pkg;

   localparam int RF_DW    = 32;
   localparam int RF_DEPTH = 32;
   localparam int RF_NRD   = 2;

   localparam logic [0:0] RF_IDLE  = 1'b0;
   localparam logic [0:0] RF_SWEEP = 1'b1;

endpackage

// File: rtl/rf_clr_seq.sv
// Soft-clear sequencer: walks an index over every register, one per cycle,
// and tells the array and scoreboard which entry to zero.
module rf_clr_seq
   import rf_pkg::*;
#(
   parameter int DEPTH = RF_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_req,
   output logic          clr_busy,
   output logic          clr_we,
   output logic [AW-1:0] clr_idx
);

   logic [0:0]    state;
   logic [AW-1:0] idx;

   // A request arriving while sweeping is ignored; exit happens on the last entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RF_IDLE;
         idx   <= '0;
      end else if (state == RF_IDLE) begin
         if (clr_req) begin
            state <= RF_SWEEP;
            idx   <= '0;
         end
      end else begin
         if (idx == AW'(DEPTH - 1)) begin
            state <= RF_IDLE;
         end else begin
            idx <= idx + AW'(1);
         end
      end
   end

   assign clr_busy = (state == RF_SWEEP);
   assign clr_we   = clr_busy;
   assign clr_idx  = idx;

endmodule

// File: rtl/rf_multiport.sv
// Multiport register file: NRD combinational reads, two writes (port 1 wins),
// pending-write scoreboard and soft clear. Define RF_BYPASS_EN for write-to-read forwarding.
module rf_multiport
   import rf_pkg::*;
#(
   parameter int DW       = RF_DW,
   parameter int DEPTH    = RF_DEPTH,
   parameter int AW       = $clog2(DEPTH),
   parameter int NRD      = RF_NRD,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NRD*AW-1:0] ra,
   output logic [NRD*DW-1:0] rdata,
   output logic [NRD-1:0]    rbusy,
   input  logic              we0,
   input  logic [AW-1:0]     wa0,
   input  logic [DW-1:0]     wd0,
   input  logic              we1,
   input  logic [AW-1:0]     wa1,
   input  logic [DW-1:0]     wd1,
   input  logic              iss_vld,
   input  logic [AW-1:0]     iss_rd,
   input  logic              clr_req,
   output logic              clr_busy
);

   logic [DW-1:0]    mem [DEPTH];
   logic [DEPTH-1:0] busy;
   logic             clr_we;
   logic [AW-1:0]    clr_idx;

   // False only for the hardwired zero register.
   function automatic logic live_reg(input logic [AW-1:0] a);
      return !((ZERO_REG != 0) && (a == '0));
   endfunction

   rf_clr_seq #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_clr_seq (
      .clk      (clk),
      .rst      (rst),
      .clr_req  (clr_req),
      .clr_busy (clr_busy),
      .clr_we   (clr_we),
      .clr_idx  (clr_idx)
   );

   // Port 1 is assigned last so it wins a same-address collision.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (clr_we) begin
         mem[clr_idx] <= '0;
      end else begin
         if (we0 && live_reg(wa0)) mem[wa0] <= wd0;
         if (we1 && live_reg(wa1)) mem[wa1] <= wd1;
      end
   end

   // Issue set is assigned after the write clears so a new producer supersedes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= '0;
      end else if (clr_we) begin
         busy[clr_idx] <= 1'b0;
      end else begin
         if (we0) busy[wa0] <= 1'b0;
         if (we1) busy[wa1] <= 1'b0;
         if (iss_vld && live_reg(iss_rd)) busy[iss_rd] <= 1'b1;
      end
   end

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic          b;

      assign a = ra[k*AW +: AW];

      always_comb begin
         d = mem[a];
         b = busy[a];
`ifdef RF_BYPASS_EN
         if (!clr_busy && live_reg(a) && ((we1 && wa1 == a) || (we0 && wa0 == a))) begin
            d = (we1 && wa1 == a) ? wd1 : wd0;
            if (!(iss_vld && iss_rd == a)) b = 1'b0;
         end
`endif
         if (!live_reg(a)) begin
            d = '0;
            b = 1'b0;
         end
      end

      assign rdata[k*DW +: DW] = d;
      assign rbusy[k]          = b;
   end

endmodule

// File: tb/tb_rf_multiport.sv
// Scoreboard bench for rf_multiport: directed scenarios plus random traffic
// checked against an array-based reference model.
module tb_rf_multiport;

   localparam int DW    = 32;
   localparam int DEPTH = 32;
   localparam int AW    = 5;
   localparam int NRD   = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [NRD*AW-1:0] ra;
   logic [NRD*DW-1:0] rdata;
   logic [NRD-1:0]    rbusy;
   logic              we0, we1, iss_vld, clr_req, clr_busy;
   logic [AW-1:0]     wa0, wa1, iss_rd;
   logic [DW-1:0]     wd0, wd1;

   rf_multiport #(
      .DW       (DW),
      .DEPTH    (DEPTH),
      .NRD      (NRD),
      .ZERO_REG (1)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .ra       (ra),
      .rdata    (rdata),
      .rbusy    (rbusy),
      .we0      (we0),
      .wa0      (wa0),
      .wd0      (wd0),
      .we1      (we1),
      .wa1      (wa1),
      .wd1      (wd1),
      .iss_vld  (iss_vld),
      .iss_rd   (iss_rd),
      .clr_req  (clr_req),
      .clr_busy (clr_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NRD*DW-1:0] rd;
      logic [NRD-1:0]    rb;
      logic              cb;
      int                tag;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference state: register contents, pending bits, remaining sweep cycles.
   logic [DW-1:0] m_mem  [DEPTH];
   logic          m_busy [DEPTH];
   int            sweep_left;
   int            sweep_pos;

   function automatic void model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         m_mem[i]  = '0;
         m_busy[i] = 1'b0;
      end
      sweep_left = 0;
      sweep_pos  = 0;
   endfunction

   // Applies the rising edge using the inputs that were stable before it.
   function automatic void model_edge();
      if (rst) begin
         model_reset();
      end else if (sweep_left > 0) begin
         m_mem[sweep_pos]  = '0;
         m_busy[sweep_pos] = 1'b0;
         sweep_pos++;
         sweep_left--;
      end else begin
         if (clr_req) begin
            sweep_left = DEPTH;
            sweep_pos  = 0;
         end
         if (we0 && wa0 != 0) m_mem[wa0] = wd0;
         if (we1 && wa1 != 0) m_mem[wa1] = wd1;
         if (we0) m_busy[wa0] = 1'b0;
         if (we1) m_busy[wa1] = 1'b0;
         if (iss_vld && iss_rd != 0) m_busy[iss_rd] = 1'b1;
      end
   endfunction

   function automatic void push_exp(input int tag);
      exp_t          e;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic          b;
      for (int k = 0; k < NRD; k++) begin
         a = ra[k*AW +: AW];
         d = m_mem[a];
         b = m_busy[a];
`ifdef RF_BYPASS_EN
         if (sweep_left == 0 && a != 0) begin
            if (we1 && wa1 == a) begin
               d = wd1;
               if (!(iss_vld && iss_rd == a)) b = 1'b0;
            end else if (we0 && wa0 == a) begin
               d = wd0;
               if (!(iss_vld && iss_rd == a)) b = 1'b0;
            end
         end
`endif
         if (a == 0) begin
            d = '0;
            b = 1'b0;
         end
         e.rd[k*DW +: DW] = d;
         e.rb[k]          = b;
      end
      e.cb  = (sweep_left > 0);
      e.tag = tag;
      q.push_back(e);
   endfunction

   // Monitor: checks every queued expectation against the outputs at the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (q.size() > 0) begin
            e = q.pop_front();
            n_cmp++;
            if (rdata !== e.rd) begin
               n_bad++;
               $display("FAIL rdata tag%0d: got %h, expected %h", e.tag, rdata, e.rd);
            end
            n_cmp++;
            if (rbusy !== e.rb) begin
               n_bad++;
               $display("FAIL rbusy tag%0d: got %b, expected %b", e.tag, rbusy, e.rb);
            end
            n_cmp++;
            if (clr_busy !== e.cb) begin
               n_bad++;
               $display("FAIL clr_busy tag%0d: got %b, expected %b", e.tag, clr_busy, e.cb);
            end
         end
      end
   end

   task automatic drive(input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                        input logic iv, input logic [AW-1:0] ir, input logic cr,
                        input logic [AW-1:0] r0, input logic [AW-1:0] r1, input int tag);
      @(posedge clk);
      #1;
      model_edge();
      we0 = w0; wa0 = a0; wd0 = d0;
      we1 = w1; wa1 = a1; wd1 = d1;
      iss_vld = iv; iss_rd = ir; clr_req = cr;
      ra = {r1, r0};
      push_exp(tag);
   endtask

   task automatic idle(input logic [AW-1:0] r0, input logic [AW-1:0] r1, input int tag);
      drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0, r0, r1, tag);
   endtask

   // Asserts rst a couple of time units into a cycle and checks before any edge.
   task automatic do_reset(input int tag);
      @(posedge clk);
      #1;
      model_edge();
      we0 = 1'b0; we1 = 1'b0; iss_vld = 1'b0; clr_req = 1'b0;
      ra = NRD*AW'($urandom);
      #1;
      rst = 1'b1;
      model_reset();
      push_exp(tag);
      @(negedge clk);
      #1;
      rst = 1'b0;
   endtask

   function automatic logic [AW-1:0] raddr();
      return ($urandom % 2 != 0) ? AW'($urandom % 8) : AW'($urandom);
   endfunction

   task automatic rand_cycle(input int tag, input bit allow_clr);
      logic [AW-1:0] a0, a1, r0;
      a0 = raddr();
      a1 = ($urandom % 4 == 0) ? a0 : raddr();
      r0 = ($urandom % 3 == 0) ? a1 : raddr();
      drive(1'($urandom), a0, DW'($urandom), 1'($urandom), a1, DW'($urandom),
            1'($urandom), ($urandom % 3 == 0) ? a0 : raddr(),
            allow_clr && ($urandom % 60 == 0), r0, raddr(), tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      we0 = 1'b0; we1 = 1'b0; iss_vld = 1'b0; clr_req = 1'b0;
      wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; iss_rd = '0;
      ra = {5'd9, 5'd3};
      model_reset();
      #1;
      push_exp(0);
      @(negedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < 30; i++) rand_cycle(1, 1'b0);
      do_reset(2);
      for (int i = 1; i < 8; i++) idle(AW'(i), AW'(i + 8), 3);

      // Same-address dual write: port 1 must win.
      drive(1'b1, 5'd5, 32'hAAAA0000, 1'b1, 5'd5, 32'h5555FFFF, 1'b0, '0, 1'b0, 5'd5, 5'd5, 4);
      idle(5'd5, 5'd0, 5);

      // Register 0 ignores writes and issue.
      drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, '0, '0, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0, 6);
      idle(5'd0, 5'd5, 7);

      // Issue and write on the same register in one cycle: issue wins.
      drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7, 1'b0, 5'd7, 5'd0, 8);
      drive(1'b1, 5'd7, 32'h0000CAFE, 1'b0, '0, '0, 1'b1, 5'd7, 1'b0, 5'd7, 5'd6, 9);
      idle(5'd7, 5'd0, 10);
      drive(1'b1, 5'd7, 32'h0000BEEF, 1'b0, '0, '0, 1'b0, '0, 1'b0, 5'd7, 5'd0, 11);
      idle(5'd7, 5'd0, 12);

      // Write and read the same register in one cycle.
      drive(1'b0, '0, '0, 1'b1, 5'd3, 32'h12345678, 1'b0, '0, 1'b0, 5'd3, 5'd3, 13);
      idle(5'd3, 5'd0, 14);

      // Soft clear over a fully populated, partly busy array.
      for (int i = 1; i < DEPTH; i++)
         drive(1'b1, AW'(i), {8'(i), 24'hA5C3E1}, 1'b0, '0, '0,
               1'($urandom), AW'(i), 1'b0, AW'(i), AW'(i - 1), 15);
      drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd9, 1'b1, 5'd9, 5'd20, 16);
      for (int i = 0; i < DEPTH + 3; i++) rand_cycle(17, 1'b1);
      for (int i = 0; i < DEPTH / 2; i++) idle(AW'(2 * i), AW'(2 * i + 1), 18);

      // Reset in the middle of a sweep.
      for (int i = 1; i < 10; i++)
         drive(1'b1, AW'(i), DW'($urandom), 1'b0, '0, '0, 1'b1, AW'(i), 1'b0, AW'(i), '0, 19);
      drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b1, 5'd1, 5'd9, 20);
      for (int i = 0; i < 4; i++) idle(AW'(i + 4), AW'(i + 1), 21);
      do_reset(22);
      for (int i = 0; i < 5; i++) idle(AW'(i + 5), AW'(i), 23);

      for (int i = 0; i < 500; i++) rand_cycle(24, 1'b1);

      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rf_multiport.md
Name: rf_multiport

Overview:
- Parametrised successor to the single-cycle 2R/1W register file; target is the pipelined core.
- Configurable data width, depth and read-port count, with two write ports.
- Adds a per-register scoreboard (pending-write busy bits) that the hazard unit reads.
- Adds a soft-clear sequencer that zeroes the array one entry per cycle without asserting rst.

Parameters:
DW, 32, data width in bits
DEPTH, 32, number of registers (power of two, >=4)
AW, $clog2(DEPTH), address width (derived; do not override)
NRD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 hardwired to zero, never written, never busy

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
ra  in  NRD*AW  packed read addresses; port k = ra[k*AW +: AW]
rdata  out  NRD*DW  packed read data, combinational from ra
rbusy  out  NRD  busy bit of the register addressed on each read port
we0  in  1  write enable, port 0
wa0  in  AW  write address, port 0
wd0  in  DW  write data, port 0
we1  in  1  write enable, port 1
wa1  in  AW  write address, port 1
wd1  in  DW  write data, port 1
iss_vld  in  1  issue strobe: mark iss_rd busy
iss_rd  in  AW  destination register of the issuing instruction
clr_req  in  1  start soft clear (single-cycle pulse or level)
clr_busy  out  1  soft clear in progress

Behaviour:
- Reset (async, rst=1):
  - all entries become 0; all busy bits become 0.
  - FSM goes to IDLE; clr_busy=0.
  - rdata reflects the zeroed array immediately.
- Read:
  - rdata[k] = array[ra[k]] combinationally; 0 cycles latency.
  - If ZERO_REG=1 and ra[k]==0: rdata[k]=0 and rbusy[k]=0.
- Write:
  - On a rising edge with weN=1, entry waN <= wdN.
  - If ZERO_REG=1, writes to address 0 are dropped.
  - Both ports writing the same address in the same cycle: port 1 wins.
- Scoreboard:
  - At the edge, iss_vld=1 sets busy[iss_rd].
  - weN=1 clears busy[waN].
  - Set and clear on the same address in the same cycle: set wins (a new producer supersedes the old one).
  - Address 0 is never set when ZERO_REG=1.
- Soft-clear FSM states: IDLE, SWEEP.
  - IDLE -> SWEEP when clr_req=1. The index counter loads 0 and clr_busy=1 from the next cycle.
  - SWEEP: each cycle entry[idx]<=0 and busy[idx]<=0, then idx++.
  - When idx==DEPTH-1 the FSM returns to IDLE; clr_busy is high for exactly DEPTH cycles.
  - In SWEEP, we0, we1 and iss_vld are ignored, and clr_req is ignored (no restart).
  - Reads in SWEEP return current contents (partially cleared); no bypass applies.
  - rst during SWEEP aborts immediately to IDLE with the array zeroed.
- Index counter is AW bits; wrap-around is not reachable because exit happens at DEPTH-1.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: write-to-read forwarding in the same cycle.
  - rdata[k] = wd1 if we1 && wa1==ra[k]; else wd0 if we0 && wa0==ra[k]; else array value.
  - Forwarding is suppressed for address 0 (when ZERO_REG=1) and during SWEEP.
  - rbusy[k] is forced 0 when a forwarding write hits ra[k], unless iss_vld targets the same register in that cycle.
- Undefined: rdata shows the old value in the write cycle and the new value from the next cycle.

Decomposition:
- Package rf_pkg holds:
  - default constants RF_DW=32, RF_DEPTH=32, RF_NRD=2;
  - FSM state encoding (RF_IDLE=1'b0, RF_SWEEP=1'b1).
- Sub-module rf_clr_seq holds the FSM plus index counter. It outputs clr_busy, clr_we and clr_idx to the array and scoreboard logic.

Test Plan:
- Reset, then reads: rst pulse mid-cycle -> all rdata=0 and rbusy=0 immediately, with no clock edge needed.
- Dual write, same address: we0 (wa0=5, wd0=0xAAAA0000) and we1 (wa1=5, wd1=0x5555FFFF) in one cycle -> next cycle ra0=5 reads 0x5555FFFF.
- Writes to register 0: we0 (wa0=0, wd0=0xFFFFFFFF) -> ra=0 reads 0; iss_vld with iss_rd=0 -> rbusy stays 0.
- Scoreboard race: iss_vld iss_rd=7, then next cycle we0 wa0=7 together with iss_vld iss_rd=7 -> busy[7] stays 1; a following write alone clears it.
- Soft clear: fill 1..31 with nonzero values, pulse clr_req -> clr_busy high exactly 32 cycles, all entries read 0 after; we0 issued during SWEEP has no effect.
- Bypass (RF_BYPASS_EN): we1 wa1=3 wd1=0x12345678 with ra0=3 in the same cycle -> rdata0=0x12345678 that cycle. Without the macro, rdata0 shows the old value that cycle and the new one next cycle.
